data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//  Shares the single data_ram port between two requesters: m0 = CPU load/store port, m1 = DMA/debug loader.
//  Sits between the core's ram_* outputs, the loader and data_ram.
//  Registered owner FSM with round-robin tie-break and a per-owner burst limit.
//  Registered read-data/ack return and a CPU stall request while m0 waits.
// PARAMETERS
//  ADDR_W     32  address width (RegBus)
//  DATA_W     32  data width (RegBus)
//  SEL_W      4   byte-select width
//  MAX_BURST  4   max consecutive grants to one owner while the other requests (>=1)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  mX_req       in   1       X=0,1: access request; addr/we/sel/wdata held stable while req=1
//  mX_we        in   1       1=write, 0=read
//  mX_addr      in   ADDR_W  byte address
//  mX_sel       in   SEL_W   byte enables
//  mX_wdata     in   DATA_W  write data
//  mX_gnt       out  1       access performed on RAM this cycle
//  mX_ack       out  1       one-cycle pulse, cycle after gnt
//  mX_rdata     out  DATA_W  read data, valid while ack=1, held until next ack
//  m0_stall_o   out  1       m0_req & ~m0_gnt, to pipeline stall logic
//  ram_ce_o     out  1       data_ram chip enable
//  ram_we_o     out  1       data_ram write enable
//  ram_addr_o   out  ADDR_W  data_ram address
//  ram_sel_o    out  SEL_W   data_ram byte select
//  ram_data_o   out  DATA_W  data_ram write data
//  ram_data_i   in   DATA_W  data_ram read data (combinational read)
// BEHAVIOUR
//  Reset (sync): state=IDLE, last=1 (m0 wins first tie), burst_cnt=0, gnt=0, ack=0, rdata=0.
//    ram_ce/we=0, ram addr/sel/data=0.
//  States: IDLE, OWN0, OWN1.
//    gnt0 = (state==OWN0)&m0_req; gnt1 = (state==OWN1)&m1_req. One access per gnt cycle.
//  RAM mux (comb): owner's we/addr/sel/wdata driven with ram_ce=1 when gntX=1.
//    Otherwise ce=we=0, addr/sel/data=0.
//  Ack: posedge after a gnt cycle -> mX_ack=1 for one cycle.
//    On a read, mX_rdata <= ram_data_i captured in that gnt cycle. Writes leave rdata unchanged.
//  Latency: req first seen in IDLE at cycle N -> gnt N+1 -> ack N+2.
//    While owning, back-to-back gnt every cycle req stays high.
//    Master drops req the cycle after gnt unless it wants another access.
//  IDLE: req0&req1 -> owner = ~last; single req -> that master; none -> IDLE.
//  OWNx, gnt issued:
//    burst_cnt==MAX_BURST-1 & other req -> OWN(other), cnt=0.
//    Else stay OWNx, cnt++ (saturating).
//  OWNx, req_x=0: other req -> OWN(other) directly, no idle bubble, cnt=0; else IDLE, cnt=0.
//  last <= X on every gnt from master X.
//  Ownership switch: new owner's gnt starts the next cycle; never two gnts in one cycle.
//  MAX_BURST=1: strict alternation under continuous contention.
//  Reset mid-access: gnt/ack removed at the reset edge; pending ack is dropped; masters re-request.
//  ram_data_o width equals DATA_W; no truncation; sel passed through unchanged.
// TESTING
//  T1 reset: hold rst 2 cyc, then no req -> all gnt/ack/ram_ce=0, rdata=0.
//  T2 single read m0: preload ram[0x10]=0xDEADBEEF, m0 read 0x10
//    -> gnt0 at N+1, ack0 at N+2, m0_rdata=0xDEADBEEF, m0_stall 1 for exactly cycle N.
//  T3 write then read m1: write 0x20=0x12345678, sel=4'b1111, then read 0x20
//    -> ram_we=1 in first gnt, ack1 twice, rdata=0x12345678.
//  T4 tie: m0,m1 req same cycle after reset -> m0 granted first; next contention -> m1 first.
//  T5 burst limit: MAX_BURST=4, m0 and m1 req continuously
//    -> gnt pattern 0,0,0,0,1,1,1,1,0... with no idle cycles; ack order matches gnt order.
//  T6 reset mid-op: assert rst in cycle of gnt1
//    -> next cycle ack1=0, state IDLE; m1 re-request is served with normal latency.

Source files
------------

// File: rtl/data_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_ram_arbiter_if
//   Request/response bundle between one data_ram requester and the arbiter.
//   Signals:
//     req    requester -> arbiter  access request; we/addr/sel/wdata held stable while req=1
//     we     requester -> arbiter  1 = write, 0 = read
//     addr   requester -> arbiter  byte address
//     sel    requester -> arbiter  byte enables
//     wdata  requester -> arbiter  write data
//     gnt    arbiter -> requester  access performed on the RAM this cycle
//     ack    arbiter -> requester  one-cycle pulse, the cycle after gnt
//     rdata  arbiter -> requester  read data, valid with ack, held until the next ack
//   Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface data_ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// data_ram_arbiter
//   Shares the single data_ram port between the CPU load/store port (m0) and
//   the DMA/debug loader (m1). A registered owner FSM picks the owner, with
//   round-robin tie-break from IDLE and a per-owner burst limit while the
//   other master waits. Ack and read data are registered; m0 gets a stall
//   request whenever it is requesting but not granted.
//   Ports:
//     clk, rst           clock (rising edge), synchronous active-high reset
//     m0, m1             requester interfaces (slave modport)
//     m0_stall_o         m0.req & ~m0.gnt, to the pipeline stall logic
//     ram_ce_o/we_o      data_ram chip / write enable
//     ram_addr_o         data_ram address
//     ram_sel_o          data_ram byte select
//     ram_data_o         data_ram write data
//     ram_data_i         data_ram read data (combinational read)
// ---------------------------------------------------------------------------
module data_ram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  data_ram_arbiter_if.slave   m0,
  data_ram_arbiter_if.slave   m1,
  output logic                m0_stall_o,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [SEL_W-1:0]    ram_sel_o,
  output logic [DATA_W-1:0]   ram_data_o,
  input  logic [DATA_W-1:0]   ram_data_i
);

  // A one-bit counter is kept even for MAX_BURST=1 so the width never collapses.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_reg;
  logic             last_reg;       // index of the master granted most recently
  logic [CNT_W-1:0] burst_cnt_reg;  // grants to the current owner, saturating

  // Flatten both interfaces into arrays so per-master logic can be generated.
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr  [2];
  logic [SEL_W-1:0]  sel   [2];
  logic [DATA_W-1:0] wdata [2];
  logic [1:0]        gnt;
  logic [1:0]        ack_reg;
  logic [DATA_W-1:0] rdata_reg [2];

  assign req      = {m1.req, m0.req};
  assign we       = {m1.we, m0.we};
  assign addr[0]  = m0.addr;
  assign addr[1]  = m1.addr;
  assign sel[0]   = m0.sel;
  assign sel[1]   = m1.sel;
  assign wdata[0] = m0.wdata;
  assign wdata[1] = m1.wdata;

  // Grants follow the registered owner; only one state can own, so at most
  // one grant is ever active.
  assign gnt[0] = (state_reg == OWN0) & req[0];
  assign gnt[1] = (state_reg == OWN1) & req[1];

  assign m0.gnt   = gnt[0];
  assign m1.gnt   = gnt[1];
  assign m0.ack   = ack_reg[0];
  assign m1.ack   = ack_reg[1];
  assign m0.rdata = rdata_reg[0];
  assign m1.rdata = rdata_reg[1];

  assign m0_stall_o = req[0] & ~gnt[0];

  // Owner FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      burst_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          burst_cnt_reg <= '0;
          if (req[0] && req[1]) begin
            // Tie goes to the master that was not served last.
            state_reg <= last_reg ? OWN0 : OWN1;
          end else if (req[0]) begin
            state_reg <= OWN0;
          end else if (req[1]) begin
            state_reg <= OWN1;
          end
        end

        OWN0: begin
          if (req[0]) begin
            last_reg <= 1'b0;
            if ((burst_cnt_reg == CNT_LAST) && req[1]) begin
              state_reg     <= OWN1;
              burst_cnt_reg <= '0;
            end else if (burst_cnt_reg != CNT_LAST) begin
              burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
          end else begin
            // Owner released: hand straight over if the other is waiting.
            state_reg     <= req[1] ? OWN1 : IDLE;
            burst_cnt_reg <= '0;
          end
        end

        OWN1: begin
          if (req[1]) begin
            last_reg <= 1'b1;
            if ((burst_cnt_reg == CNT_LAST) && req[0]) begin
              state_reg     <= OWN0;
              burst_cnt_reg <= '0;
            end else if (burst_cnt_reg != CNT_LAST) begin
              burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
          end else begin
            state_reg     <= req[0] ? OWN0 : IDLE;
            burst_cnt_reg <= '0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          burst_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Per-master ack pulse and read-data capture. Reset drops any pending ack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        ack_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        ack_q <= gnt[gi];
        if (gnt[gi] && !we[gi]) begin
          rdata_q <= ram_data_i;
        end
      end
    end

    assign ack_reg[gi]   = ack_q;
    assign rdata_reg[gi] = rdata_q;
  end

  // RAM port mux: the granted master drives the RAM, otherwise all zero.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (gnt[0]) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = we[0];
      ram_addr_o = addr[0];
      ram_sel_o  = sel[0];
      ram_data_o = wdata[0];
    end else if (gnt[1]) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = we[1];
      ram_addr_o = addr[1];
      ram_sel_o  = sel[1];
      ram_data_o = wdata[1];
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_ram_arbiter
//   Bench for data_ram_arbiter (MAX_BURST=4) with a behavioural data_ram.
//   A cycle table drives both requesters and states the expected gnt/ack/
//   stall pattern; each expected grant pushes the expected response into a
//   per-master queue that a negedge monitor pops on every ack.
// ---------------------------------------------------------------------------
module tb_data_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) m0_if ();
  data_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) m1_if ();

  logic          m0_stall;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [SW-1:0] ram_sel;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .m0_stall_o (m0_stall),
    .ram_ce_o   (ram_ce),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_sel_o  (ram_sel),
    .ram_data_o (ram_wdata),
    .ram_data_i (ram_rdata)
  );

  // Behavioural data_ram: combinational read, byte-masked write.
  logic [31:0] mem [256];
  logic        loaded = 1'b0;
  assign ram_rdata = mem[ram_addr[9:2]];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
      mem[4] <= 32'hDEAD_BEEF;
      loaded <= 1'b1;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Bench-side expected memory contents.
  logic [31:0] exp_mem [256];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: one entry per expected grant.
  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } sb_t;
  sb_t q0[$];
  sb_t q1[$];
  logic [31:0] exp_rd0;
  logic [31:0] exp_rd1;

  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      q0.delete();
      q1.delete();
      exp_rd0 = '0;
      exp_rd1 = '0;
    end else begin
      if (m0_if.ack) begin
        if (q0.size() == 0) begin
          chk("ack0_unexpected", 64'(m0_if.ack), 64'd0);
        end else begin
          e = q0.pop_front();
          if (!e.we) exp_rd0 = e.data;
          chk("m0_rdata", 64'(m0_if.rdata), 64'(exp_rd0));
          $display("ack m0 %s rdata=%h", e.we ? "write" : "read", m0_if.rdata);
        end
      end
      if (m1_if.ack) begin
        if (q1.size() == 0) begin
          chk("ack1_unexpected", 64'(m1_if.ack), 64'd0);
        end else begin
          e = q1.pop_front();
          if (!e.we) exp_rd1 = e.data;
          chk("m1_rdata", 64'(m1_if.rdata), 64'(exp_rd1));
          $display("ack m1 %s rdata=%h", e.we ? "write" : "read", m1_if.rdata);
        end
      end
    end
  end

  // Cycle table: inputs for both masters and expected {g0,g1,k0,k1,stall}.
  typedef struct {
    logic        r0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [4:0]  exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic [4:0] exp);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.sel = 4'hF;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.sel = 4'hF;
  endtask

  task automatic push_exp(input int m, input logic w, input logic [31:0] a, input logic [31:0] d);
    sb_t e;
    e.we   = w;
    e.data = w ? 32'h0 : exp_mem[a[9:2]];
    if (w) exp_mem[a[9:2]] = d;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  initial begin
    logic        eg0, eg1, ece, ewe;
    logic [31:0] eaddr, edata;

    for (int i = 0; i < 256; i++) exp_mem[i] = 32'hC0DE_0000 | i;
    exp_mem[4] = 32'hDEAD_BEEF;

    // T2: single m0 read of 0x10.
    add(1,0,'h10,0, 0,0,0,0, 5'b00001);
    add(1,0,'h10,0, 0,0,0,0, 5'b10000);
    add(0,0,0,0,    0,0,0,0, 5'b00100);
    add(0,0,0,0,    0,0,0,0, 5'b00000);
    // T3: m1 write 0x20 then read it back in the following grant.
    add(0,0,0,0, 1,1,'h20,'h12345678, 5'b00000);
    add(0,0,0,0, 1,1,'h20,'h12345678, 5'b01000);
    add(0,0,0,0, 1,0,'h20,0,          5'b01010);
    add(0,0,0,0, 0,0,0,0,             5'b00010);
    add(0,0,0,0, 0,0,0,0,             5'b00000);
    // T4: tie after m1 served last -> m0; m0 single; tie again -> m1.
    add(1,0,'h10,0, 1,0,'h24,0, 5'b00001);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b10000);
    add(0,0,0,0,    1,0,'h24,0, 5'b00100);
    add(0,0,0,0,    1,0,'h24,0, 5'b01000);
    add(0,0,0,0,    0,0,0,0,    5'b00010);
    add(1,0,'h10,0, 0,0,0,0,    5'b00001);
    add(1,0,'h10,0, 0,0,0,0,    5'b10000);
    add(0,0,0,0,    0,0,0,0,    5'b00100);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b00001);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b01001);
    add(1,0,'h10,0, 0,0,0,0,    5'b00011);
    add(1,0,'h10,0, 0,0,0,0,    5'b10000);
    add(0,0,0,0,    0,0,0,0,    5'b00100);
    add(0,0,0,0,    0,0,0,0,    5'b00000);
    // T5: continuous contention, burst limit 4 (m0 was served last -> m1 starts).
    add(1,0,'h10,0, 1,0,'h24,0, 5'b00001);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b01001);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b01011);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b01011);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b01011);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b10010);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b10100);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b10100);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b10100);
    add(1,0,'h10,0, 1,0,'h24,0, 5'b01101);
    add(0,0,0,0,    0,0,0,0,    5'b00010);
    add(0,0,0,0,    0,0,0,0,    5'b00000);

    // T1: reset held two cycles, then idle.
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("t1_gnt0",   64'(m0_if.gnt),   64'd0);
    chk("t1_gnt1",   64'(m1_if.gnt),   64'd0);
    chk("t1_ce",     64'(ram_ce),      64'd0);
    chk("t1_stall",  64'(m0_stall),    64'd0);
    next_cyc();
    #3;
    chk("t1_ack0",   64'(m0_if.ack),   64'd0);
    chk("t1_ack1",   64'(m1_if.ack),   64'd0);
    chk("t1_rdata0", 64'(m0_if.rdata), 64'd0);
    chk("t1_rdata1", 64'(m1_if.rdata), 64'd0);
    $display("t1 reset gnt0=%b gnt1=%b ce=%b", m0_if.gnt, m1_if.gnt, ram_ce);
    next_cyc();

    // Table-driven cycles.
    for (int i = 0; i < tbl.size(); i++) begin
      m0_if.req = tbl[i].r0; m0_if.we = tbl[i].w0; m0_if.addr = tbl[i].a0; m0_if.wdata = tbl[i].d0;
      m1_if.req = tbl[i].r1; m1_if.we = tbl[i].w1; m1_if.addr = tbl[i].a1; m1_if.wdata = tbl[i].d1;
      eg0   = tbl[i].exp[4];
      eg1   = tbl[i].exp[3];
      ece   = eg0 | eg1;
      ewe   = eg0 ? tbl[i].w0 : (eg1 ? tbl[i].w1 : 1'b0);
      eaddr = eg0 ? tbl[i].a0 : (eg1 ? tbl[i].a1 : 32'h0);
      edata = eg0 ? tbl[i].d0 : (eg1 ? tbl[i].d1 : 32'h0);
      if (eg0) push_exp(0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
      if (eg1) push_exp(1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      #3;
      chk($sformatf("row%0d_ctl", i),
          64'({m0_if.gnt, m1_if.gnt, m0_if.ack, m1_if.ack, m0_stall, ram_ce, ram_we}),
          64'({tbl[i].exp, ece, ewe}));
      if (ece) begin
        chk($sformatf("row%0d_addr", i), 64'(ram_addr), 64'(eaddr));
        chk($sformatf("row%0d_sel", i), 64'(ram_sel), 64'(4'hF));
        if (ewe) chk($sformatf("row%0d_wdata", i), 64'(ram_wdata), 64'(edata));
      end
      $display("row%0d req=%b%b gnt=%b%b ack=%b%b stall=%b", i, m0_if.req, m1_if.req,
               m0_if.gnt, m1_if.gnt, m0_if.ack, m1_if.ack, m0_stall);
      next_cyc();
    end

    // T6: reset during m1's grant cycle drops the pending ack.
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h24;
    #3;
    chk("t6_wait_gnt1", 64'(m1_if.gnt), 64'd0);
    next_cyc();
    rst = 1'b1;
    #3;
    chk("t6_gnt1", 64'(m1_if.gnt), 64'd1);
    next_cyc();
    rst = 1'b0;
    #3;
    chk("t6_ack1_dropped", 64'(m1_if.ack),   64'd0);
    chk("t6_gnt1_idle",    64'(m1_if.gnt),   64'd0);
    chk("t6_rdata1_clr",   64'(m1_if.rdata), 64'd0);
    chk("t6_rdata0_clr",   64'(m0_if.rdata), 64'd0);
    $display("t6 reset mid-access ack1=%b gnt1=%b", m1_if.ack, m1_if.gnt);
    next_cyc();
    push_exp(1, 1'b0, 32'h24, 32'h0);
    #3;
    chk("t6_regnt1", 64'(m1_if.gnt), 64'd1);
    next_cyc();
    m1_if.req = 1'b0;
    #3;
    chk("t6_reack1", 64'(m1_if.ack), 64'd1);
    next_cyc();
    next_cyc();

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
